instr_mem_fetch: RTL and testbench

//  Parametrised, loadable instruction memory with a clocked fetch handshake and

---
 rtl/instr_mem_fetch_if.sv | 33 +++
 rtl/instr_mem_fetch.sv | 175 +++++++++++++++++
 tb/tb_instr_mem_fetch.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_fetch_if
//  Description : Fetch request/response and program-load bundle of the
//                instruction memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_mem_fetch_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] address;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       data;
    logic              fault;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic              load_ack;

    modport master (
        output req_valid, address, resp_ready, load_en, load_addr, load_data,
        input  req_ready, resp_valid, data, fault, load_ack
    );

    modport slave (
        input  req_valid, address, resp_ready, load_en, load_addr, load_data,
        output req_ready, resp_valid, data, fault, load_ack
    );
endinterface
`default_nettype wire

// File: rtl/instr_mem_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_fetch
//  Description : Loadable instruction memory with valid/ready fetch and
//                RD_WAIT read wait states. Define INSTR_MEM_PREFETCH_EN for a
//                one-entry next-word prefetch buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_mem_fetch #(
    parameter int          ADDR_W       = 64,
    parameter int          DEPTH        = 64,
    parameter int          RD_WAIT      = 0,
    parameter logic [31:0] DEFAULT_WORD = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    instr_mem_fetch_if.slave bus
);
    localparam int c_IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
    localparam logic [ADDR_W-3:0] c_DEPTH = (ADDR_W-2)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_resp_valid;
    logic               r_fault_out;
    logic [31:0]        r_data;
    logic               r_load_ack;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_req_fault;
    logic [31:0]        r_mem [DEPTH];

    logic               w_req_ready;
    logic               w_accept;
    logic               w_req_fault;
    logic               w_load_do;
    logic               w_load_fault;
    logic               w_hit;
    logic [c_IDX_W-1:0] w_req_idx;
    logic [c_IDX_W-1:0] w_load_idx;
    logic [31:0]        w_imm_word;

    // Misaligned, or word index at/after DEPTH (any upper address bit counts).
    function automatic logic f_fault(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a[ADDR_W-1:2] >= c_DEPTH);
    endfunction

    always_comb begin
        w_req_ready = 1'b0;
        case (r_state)
            S_IDLE:  w_req_ready = ~bus.load_en;
            S_RESP:  w_req_ready = bus.resp_ready;
            default: w_req_ready = 1'b0;
        endcase
    end

    assign w_accept     = bus.req_valid & w_req_ready;
    assign w_req_fault  = f_fault(bus.address);
    assign w_req_idx    = bus.address[c_IDX_W+1:2];
    assign w_load_do    = (r_state == S_IDLE) & bus.load_en;
    assign w_load_fault = f_fault(bus.load_addr);
    assign w_load_idx   = bus.load_addr[c_IDX_W+1:2];

    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!rst && w_load_do && !w_load_fault) begin
            r_mem[w_load_idx] <= bus.load_data;
        end
    end

`ifdef INSTR_MEM_PREFETCH_EN
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_pf_addr;
    logic [31:0]       r_pf_data;
    logic              r_pf_valid;
    logic              r_pf_pend;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_buf_hit;
    logic              w_pend_hit;

    assign w_next_addr = r_addr + ADDR_W'(4);
    assign w_buf_hit   = r_pf_valid && (bus.address == r_pf_addr);
    // A request for the word being prefetched this very cycle is a hit too.
    assign w_pend_hit  = r_pf_pend && (bus.address == w_next_addr);
    assign w_hit       = w_buf_hit | w_pend_hit;
    assign w_imm_word  = w_buf_hit ? r_pf_data : r_mem[w_req_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_pf_addr  <= '0;
            r_pf_data  <= '0;
            r_pf_valid <= 1'b0;
            r_pf_pend  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= bus.address;
            end
            r_pf_pend <= (r_state == S_RESP) && bus.resp_ready && !bus.req_valid
                         && !r_fault_out && !f_fault(w_next_addr);
            if (w_load_do) begin
                r_pf_valid <= 1'b0;
            end else if (r_pf_pend && (!w_accept || w_pend_hit)) begin
                r_pf_valid <= 1'b1;
                r_pf_addr  <= w_next_addr;
                r_pf_data  <= r_mem[w_next_addr[c_IDX_W+1:2]];
            end
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_imm_word = r_mem[w_req_idx];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_fault_out  <= 1'b0;
            r_data       <= '0;
            r_load_ack   <= 1'b0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_req_fault  <= 1'b0;
        end else begin
            r_load_ack <= w_load_do;
            if (w_accept) begin
                r_idx       <= w_req_idx;
                r_req_fault <= w_req_fault;
                if (RD_WAIT == 0 || w_hit) begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_fault_out  <= w_req_fault;
                    r_data       <= w_req_fault ? DEFAULT_WORD : w_imm_word;
                end else begin
                    r_state      <= S_WAIT;
                    r_resp_valid <= 1'b0;
                    r_cnt        <= c_CNT_W'(RD_WAIT);
                end
            end else begin
                case (r_state)
                    S_WAIT: begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                        if (r_cnt == c_CNT_W'(1)) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_fault_out  <= r_req_fault;
                            r_data       <= r_req_fault ? DEFAULT_WORD : r_mem[r_idx];
                        end
                    end
                    S_RESP: begin
                        if (bus.resp_ready) begin
                            r_state      <= S_IDLE;
                            r_resp_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.data       = r_data;
    assign bus.fault      = r_fault_out;
    assign bus.load_ack   = r_load_ack;
endmodule
`default_nettype wire

// File: tb/tb_instr_mem_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_mem_fetch
//  Description : Directed bench; one RD_WAIT=0 and one RD_WAIT=3 instance
//                driven with identical stimulus, one of them observed at a time.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_mem_fetch;
    localparam logic [31:0] c_DW = 32'hDEAD_BEEF;
`ifdef INSTR_MEM_PREFETCH_EN
    localparam int c_PF_LAT = 1;
`else
    localparam int c_PF_LAT = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [63:0] address = '0;
    logic        resp_ready = 1'b1;
    logic        load_en = 1'b0;
    logic [63:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        sel3 = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    instr_mem_fetch_if #(.ADDR_W(64)) if0 ();
    instr_mem_fetch_if #(.ADDR_W(64)) if3 ();

    assign if0.req_valid  = req_valid;
    assign if0.address    = address;
    assign if0.resp_ready = resp_ready;
    assign if0.load_en    = load_en;
    assign if0.load_addr  = load_addr;
    assign if0.load_data  = load_data;
    assign if3.req_valid  = req_valid;
    assign if3.address    = address;
    assign if3.resp_ready = resp_ready;
    assign if3.load_en    = load_en;
    assign if3.load_addr  = load_addr;
    assign if3.load_data  = load_data;

    instr_mem_fetch #(.ADDR_W(64), .DEPTH(64), .RD_WAIT(0), .DEFAULT_WORD(c_DW)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    instr_mem_fetch #(.ADDR_W(64), .DEPTH(64), .RD_WAIT(3), .DEFAULT_WORD(c_DW)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    logic        s_ready, s_rvalid, s_fault, s_ack;
    logic [31:0] s_data;
    assign s_ready  = sel3 ? if3.req_ready  : if0.req_ready;
    assign s_rvalid = sel3 ? if3.resp_valid : if0.resp_valid;
    assign s_fault  = sel3 ? if3.fault      : if0.fault;
    assign s_ack    = sel3 ? if3.load_ack   : if0.load_ack;
    assign s_data   = sel3 ? if3.data       : if0.data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [63:0] a, input logic [31:0] d, input string tag);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        chk({tag, "_ack"}, s_ack, 1);
        load_en = 1'b0;
        tick();
        chk({tag, "_ackfall"}, s_ack, 0);
    endtask

    task automatic fetch(input logic [63:0] a, input int exp_lat, input logic [31:0] exp_d,
                         input logic exp_f, input string tag);
        int n;
        int lat;
        req_valid = 1'b1;
        address   = a;
        #1;
        n = 0;
        while (!s_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_rdy"}, s_ready, 1);
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!s_rvalid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_data"}, s_data, exp_d);
        chk({tag, "_fault"}, s_fault, exp_f);
        tick();
        chk({tag, "_done"}, s_rvalid, 0);
        repeat (6) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (3) tick();
        // Reset values of both instances while reset is held.
        for (int s = 0; s < 2; s++) begin
            sel3 = (s == 1);
            #1;
            chk("rst_rvalid", s_rvalid, 0);
            chk("rst_data", s_data, 0);
            chk("rst_fault", s_fault, 0);
            chk("rst_ack", s_ack, 0);
            chk("rst_ready", s_ready, 1);
        end
        rst  = 1'b0;
        sel3 = 1'b0;
        tick();

        // Test 1: RD_WAIT=0 program load and fetch.
        do_load(64'h0,  32'hF840_03E9, "t1_ld0");
        do_load(64'h4,  32'hF840_83EA, "t1_ld4");
        do_load(64'h8,  32'hF841_03EB, "t1_ld8");
        do_load(64'hFC, 32'h1234_5678, "t1_ldFC");
        fetch(64'h4, 1, 32'hF840_83EA, 1'b0, "t1_f4");
        fetch(64'h8, 1, 32'hF841_03EB, 1'b0, "t1_f8");

        // Test 2: RD_WAIT=3 latency, including the last in-range word.
        sel3 = 1'b1;
        fetch(64'h8,  4, 32'hF841_03EB, 1'b0, "t2_f8");
        fetch(64'hFC, 4, 32'h1234_5678, 1'b0, "t2_fFC");

        // Test 3: backpressure, load ignored outside IDLE, then back-to-back.
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        address    = 64'h4;
        #1;
        tick();
        address = 64'h0;
        lat = 1;
        while (!s_rvalid && lat < 20) begin
            tick();
            lat++;
        end
        chk("t3_lat", lat, 4);
        chk("t3_data", s_data, 32'hF840_83EA);
        load_en   = 1'b1;
        load_addr = 64'h4;
        load_data = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_rvalid", s_rvalid, 1);
            chk("t3_hold_data", s_data, 32'hF840_83EA);
            chk("t3_hold_ready", s_ready, 0);
            chk("t3_hold_noack", s_ack, 0);
        end
        load_en    = 1'b0;
        resp_ready = 1'b1;
        #1;
        chk("t3_b2b_ready", s_ready, 1);
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!s_rvalid && lat < 20) begin
            tick();
            lat++;
        end
        chk("t3_b2b_lat", lat, 4);
        chk("t3_b2b_data", s_data, 32'hF840_03E9);
        tick();
        repeat (6) tick();

        // Test 4: faults, dropped loads, load/request collision.
        sel3 = 1'b0;
        fetch(64'h6, 1, c_DW, 1'b1, "t4_misal");
        fetch(64'h100, 1, c_DW, 1'b1, "t4_oor");
        fetch(64'h8000_0000_0000_0004, 1, c_DW, 1'b1, "t4_upper");
        do_load(64'h6,   32'h1111_1111, "t4_ld_misal");
        do_load(64'h100, 32'h2222_2222, "t4_ld_oor");
        fetch(64'h4, 1, 32'hF840_83EA, 1'b0, "t4_keep4");
        fetch(64'h0, 1, 32'hF840_03E9, 1'b0, "t4_keep0");
        load_en   = 1'b1;
        load_addr = 64'h10;
        load_data = 32'hA5A5_A5A5;
        req_valid = 1'b1;
        address   = 64'h10;
        #1;
        chk("t4_coll_ready", s_ready, 0);
        tick();
        chk("t4_coll_ack", s_ack, 1);
        chk("t4_coll_noresp", s_rvalid, 0);
        load_en = 1'b0;
        fetch(64'h10, 1, 32'hA5A5_A5A5, 1'b0, "t4_coll");

        // Test 5: reset mid-WAIT discards the fetch, memory survives.
        sel3      = 1'b1;
        req_valid = 1'b1;
        address   = 64'h0;
        #1;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rvalid", s_rvalid, 0);
        chk("t5_ready", s_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_quiet", s_rvalid, 0);
        end
        fetch(64'h0, 4, 32'hF840_03E9, 1'b0, "t5_refetch");

        // Test 6: sequential fetch latency with and without an intervening load.
        fetch(64'h0, 4, 32'hF840_03E9, 1'b0, "t6_a");
        fetch(64'h4, c_PF_LAT, 32'hF840_83EA, 1'b0, "t6_b");
        fetch(64'h0, 4, 32'hF840_03E9, 1'b0, "t6_c");
        do_load(64'h4, 32'h8B09_01AD, "t6_ld");
        fetch(64'h4, 4, 32'h8B09_01AD, 1'b0, "t6_d");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
